core_data_mem: RTL and testbench

//  Responder for the core's data-memory port: serves mem_en_load/mem_en_store

---
 rtl/core_data_mem.sv | 116 +++++++++++
 tb/tb_core_data_mem.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/core_data_mem.sv
// Data-memory responder: byte RAM below IO_BASE, 8-byte IO window above.
// Ports: clk, rst (sync, active-low), mem_en_load/store, mem_addr, mem_store,
//   mem_load (comb), io_input (async), io_output (latch), fault (sticky).
module core_data_mem #(
  parameter int                ADDR_W  = 10,
  parameter int                DATA_W  = 8,
  parameter logic [ADDR_W-1:0] IO_BASE = 10'h3F8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_en_store,
  input  logic              mem_en_load,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_store,
  output logic [DATA_W-1:0] mem_load,
  input  logic [DATA_W-1:0] io_input,
  output logic [DATA_W-1:0] io_output,
  output logic              fault
);

  localparam int RAM_D = int'(IO_BASE);

  logic [DATA_W-1:0] ram_q [RAM_D];

  logic [DATA_W-1:0] out_q, out_d;
  logic [DATA_W-1:0] sync1_q, sync1_d;
  logic [DATA_W-1:0] sync2_q, sync2_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0] shadow_q, shadow_d;
  logic              fault_q, fault_d;

  logic [ADDR_W-1:0] io_off;
  logic is_ram;
  logic sel_out, sel_in, sel_cntl, sel_cnth, sel_stat;
  logic ram_we;
  logic f_set, f_clr;

  always_comb begin
    io_off   = mem_addr - IO_BASE;
    is_ram   = mem_addr < IO_BASE;
    sel_out  = !is_ram && io_off == ADDR_W'(0);
    sel_in   = !is_ram && io_off == ADDR_W'(1);
    sel_cntl = !is_ram && io_off == ADDR_W'(2);
    sel_cnth = !is_ram && io_off == ADDR_W'(3);
    sel_stat = !is_ram && io_off == ADDR_W'(4);
    ram_we   = mem_en_store && is_ram;
  end

  // Async read; on a dual-request cycle this still shows pre-store state.
  always_comb begin
    mem_load = '0;
    if (mem_en_load) begin
      unique case (1'b1)
        is_ram:   mem_load = ram_q[mem_addr];
        sel_out:  mem_load = out_q;
        sel_in:   mem_load = sync2_q;
        sel_cntl: mem_load = cnt_q[7:0];
        sel_cnth: mem_load = shadow_q;
        sel_stat: mem_load = {{(DATA_W-1){1'b0}}, fault_q};
        default:  mem_load = '0;
      endcase
    end
  end

  always_comb begin
    out_d    = out_q;
    sync1_d  = io_input;
    sync2_d  = sync1_q;
    cnt_d    = cnt_q + 16'd1;
    shadow_d = shadow_q;
    f_set    = (mem_en_load && mem_en_store)
            || (mem_en_store && (sel_in || sel_cnth));
    f_clr    = mem_en_store && sel_stat && mem_store[0];
    fault_d  = fault_q;
    if (mem_en_store && sel_out)
      out_d = mem_store;
    // Clear wins over the free-running increment.
    if (mem_en_store && sel_cntl)
      cnt_d = '0;
    // Latch the high byte so CNT_H pairs with the CNT_L just read.
    if (mem_en_load && sel_cntl)
      shadow_d = cnt_q[15:8];
    if (f_set)
      fault_d = 1'b1;
    else if (f_clr)
      fault_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_q    <= '0;
      sync1_q  <= '0;
      sync2_q  <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      fault_q  <= 1'b0;
    end else begin
      out_q    <= out_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      fault_q  <= fault_d;
    end
  end

  // RAM keeps its contents through reset, but a store during reset is lost.
  always_ff @(posedge clk) begin
    if (rst && ram_we)
      ram_q[mem_addr] <= mem_store;
  end

  assign io_output = out_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_core_data_mem.sv
// Self-checking bench for core_data_mem.
// Vector table plus hand sequences; expectations flow through a queue.
module tb_core_data_mem;

  logic       clk;
  logic       rst;
  logic       st, ld;
  logic [9:0] addr;
  logic [7:0] wd;
  logic [7:0] mem_load;
  logic [7:0] io_in;
  logic [7:0] io_output;
  logic       fault;

  core_data_mem dut (
    .clk          (clk),
    .rst          (rst),
    .mem_en_store (st),
    .mem_en_load  (ld),
    .mem_addr     (addr),
    .mem_store    (wd),
    .mem_load     (mem_load),
    .io_input     (io_in),
    .io_output    (io_output),
    .fault        (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [9:0] A_OUT  = 10'h3F8;
  localparam logic [9:0] A_IN   = 10'h3F9;
  localparam logic [9:0] A_CNTL = 10'h3FA;
  localparam logic [9:0] A_CNTH = 10'h3FB;
  localparam logic [9:0] A_STAT = 10'h3FC;

  typedef enum int { K_LOAD, K_OUT, K_FAULT } kind_e;

  typedef struct {
    string      nm;
    kind_e      k;
    logic [7:0] v;
  } exp_t;

  typedef struct {
    string      nm;
    logic       ld;
    logic       st;
    logic [9:0] addr;
    logic [7:0] wd;
    logic [7:0] e_ld;
    logic [7:0] e_out;
    logic       e_f;
  } vec_t;

  exp_t sbq[$];
  vec_t tv[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(string nm, logic l, logic s,
                              logic [9:0] a, logic [7:0] d,
                              logic [7:0] el, logic [7:0] eo,
                              logic ef);
    vec_t v;
    v.nm = nm; v.ld = l; v.st = s; v.addr = a; v.wd = d;
    v.e_ld = el; v.e_out = eo; v.e_f = ef;
    return v;
  endfunction

  function automatic void push(string nm, kind_e k, logic [7:0] v);
    exp_t e;
    e.nm = nm; e.k = k; e.v = v;
    sbq.push_back(e);
  endfunction

  task automatic pop_check();
    exp_t       e;
    logic [7:0] act;
    n_cmp++;
    if (sbq.size() == 0) begin
      n_bad++;
      $display("FAIL sb_empty: no expectation queued");
    end else begin
      e = sbq.pop_front();
      unique case (e.k)
        K_LOAD:  act = mem_load;
        K_OUT:   act = io_output;
        default: act = {7'b0, fault};
      endcase
      if (act !== e.v) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h", e.nm, act, e.v);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ld = 1'b0;
    st = 1'b0;
  endtask

  task automatic ld_chk(string nm, logic [9:0] a, logic [7:0] ev);
    ld   = 1'b1;
    st   = 1'b0;
    addr = a;
    push(nm, K_LOAD, ev);
    #2;
    pop_check();
  endtask

  task automatic st_do(logic [9:0] a, logic [7:0] d);
    ld   = 1'b0;
    st   = 1'b1;
    addr = a;
    wd   = d;
    tick();
  endtask

  task automatic post_chk(string nm, logic [7:0] eo, logic ef);
    push({nm, "_out"}, K_OUT, eo);
    push({nm, "_flt"}, K_FAULT, {7'b0, ef});
    pop_check();
    pop_check();
  endtask

  initial begin
    tv.push_back(mk("ram_wr",   0, 1, 10'h005, 8'hA5, 8'h00, 8'h00, 0));
    tv.push_back(mk("ram_rd",   1, 0, 10'h005, 8'h00, 8'hA5, 8'h00, 0));
    tv.push_back(mk("ld_off",   0, 0, 10'h005, 8'h00, 8'h00, 8'h00, 0));
    tv.push_back(mk("out_wr",   0, 1, A_OUT,   8'h3C, 8'h00, 8'h3C, 0));
    tv.push_back(mk("out_rd",   1, 0, A_OUT,   8'h00, 8'h3C, 8'h3C, 0));
    tv.push_back(mk("ram_wr2",  0, 1, 10'h010, 8'h11, 8'h00, 8'h3C, 0));
    tv.push_back(mk("dual",     1, 1, 10'h010, 8'h77, 8'h11, 8'h3C, 1));
    tv.push_back(mk("ram_rd2",  1, 0, 10'h010, 8'h00, 8'h77, 8'h3C, 1));
    tv.push_back(mk("stat_rd1", 1, 0, A_STAT,  8'h00, 8'h01, 8'h3C, 1));
    tv.push_back(mk("stat_nc",  0, 1, A_STAT,  8'hFE, 8'h00, 8'h3C, 1));
    tv.push_back(mk("stat_clr", 0, 1, A_STAT,  8'h01, 8'h00, 8'h3C, 0));
    tv.push_back(mk("stat_rd0", 1, 0, A_STAT,  8'h00, 8'h00, 8'h3C, 0));
    tv.push_back(mk("res_st",   0, 1, 10'h3FE, 8'hFF, 8'h00, 8'h3C, 0));
    tv.push_back(mk("res_ld",   1, 0, 10'h3FD, 8'h00, 8'h00, 8'h3C, 0));
    tv.push_back(mk("res_ld7",  1, 0, 10'h3FF, 8'h00, 8'h00, 8'h3C, 0));
    tv.push_back(mk("st_cnth",  0, 1, A_CNTH,  8'h12, 8'h00, 8'h3C, 1));
    tv.push_back(mk("set_clr",  1, 1, A_STAT,  8'h01, 8'h01, 8'h3C, 1));
    tv.push_back(mk("clr2",     0, 1, A_STAT,  8'hFF, 8'h00, 8'h3C, 0));
    tv.push_back(mk("st_in",    0, 1, A_IN,    8'hAA, 8'h00, 8'h3C, 1));
    tv.push_back(mk("in_rd",    1, 0, A_IN,    8'h00, 8'h00, 8'h3C, 1));
    tv.push_back(mk("clr3",     0, 1, A_STAT,  8'h01, 8'h00, 8'h3C, 0));
    tv.push_back(mk("ram_top",  0, 1, 10'h3F7, 8'hC3, 8'h00, 8'h3C, 0));
    tv.push_back(mk("ram_topr", 1, 0, 10'h3F7, 8'h00, 8'hC3, 8'h3C, 0));
    tv.push_back(mk("ram0",     0, 1, 10'h000, 8'h5E, 8'h00, 8'h3C, 0));
    tv.push_back(mk("ram0r",    1, 0, 10'h000, 8'h00, 8'h5E, 8'h3C, 0));

    rst = 1'b0; ld = 1'b0; st = 1'b0;
    addr = '0; wd = '0; io_in = '0;

    // Reset, then counter reads 1 in the first cycle after release.
    repeat (2) @(posedge clk);
    #1;
    post_chk("rst", 8'h00, 1'b0);
    rst = 1'b1;
    tick();
    ld_chk("cnt_first", A_CNTL, 8'h01);
    ld_chk("shadow_rst", A_CNTH, 8'h00);
    tick();

    foreach (tv[i]) begin
      ld   = tv[i].ld;
      st   = tv[i].st;
      addr = tv[i].addr;
      wd   = tv[i].wd;
      push(tv[i].nm, K_LOAD, tv[i].e_ld);
      #2;
      pop_check();
      tick();
      post_chk(tv[i].nm, tv[i].e_out, tv[i].e_f);
    end

    // Input synchroniser: two-cycle latency.
    io_in = 8'h5A;
    ld_chk("sync_n", A_IN, 8'h00);
    tick();
    ld_chk("sync_n1", A_IN, 8'h00);
    tick();
    ld_chk("sync_n2", A_IN, 8'h5A);
    tick();
    ld_chk("sync_n3", A_IN, 8'h5A);
    tick();

    // Clear beats increment; CNT_H is coherent across the FF->100 carry.
    st_do(A_CNTL, 8'h00);
    ld_chk("cnt_clr", A_CNTL, 8'h00);
    repeat (255) tick();
    ld_chk("cnt_ff", A_CNTL, 8'hFF);
    tick();
    ld_chk("cnth_coh", A_CNTH, 8'h00);
    ld_chk("cntl_100", A_CNTL, 8'h00);
    tick();
    ld_chk("cnth_01", A_CNTH, 8'h01);
    tick();

    // Full 16-bit wrap.
    st_do(A_CNTL, 8'h00);
    repeat (65535) @(posedge clk);
    #1;
    ld_chk("wrap_ff", A_CNTL, 8'hFF);
    tick();
    ld_chk("wrap_h_ff", A_CNTH, 8'hFF);
    ld_chk("wrap_l_00", A_CNTL, 8'h00);
    tick();
    ld_chk("wrap_h_00", A_CNTH, 8'h00);
    tick();

    // Reset mid-operation: stores dropped, RAM kept, counter restarts.
    st_do(10'h020, 8'h44);
    st_do(A_STAT, 8'h00);
    st_do(A_CNTH, 8'h00);
    post_chk("pre_rst", 8'h3C, 1'b1);
    rst = 1'b0;
    st_do(A_OUT, 8'hFF);
    post_chk("rst_st_out", 8'h00, 1'b0);
    rst = 1'b0;
    st_do(10'h020, 8'h99);
    rst = 1'b1;
    ld_chk("rst_ram_drop", 10'h020, 8'h44);
    ld_chk("rst_ram_keep", 10'h005, 8'hA5);
    ld_chk("rst_cnt0", A_CNTL, 8'h00);
    tick();
    ld_chk("rst_cnt1", A_CNTL, 8'h01);
    tick();

    if (sbq.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sb_left: %0d entries remain, expected 0", sbq.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
